// File: rtl/sc_io_pkg.sv
// rtl/sc_io_pkg.sv - shared I/O map constants and key bit layout for the key input path
package sc_io_pkg;

  localparam logic [31:0] KEY1_ADDR    = 32'h8000_0000;
  localparam logic [31:0] KEY2_ADDR    = 32'h8000_0004;
  localparam logic [31:0] KEY3_ADDR    = 32'h8000_0008;
  localparam logic [31:0] DISPLAY_ADDR = 32'h8000_000C;

  localparam int KEY1_IDX = 0;
  localparam int KEY2_LSB = 1;
  localparam int KEY3_LSB = 5;
  localparam int NUM_KEYS = 9;

  // Level a released pin sits at, so the synchroniser resets to "not pressed".
  function automatic logic raw_idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sc_debounce_bit.sv
// rtl/sc_debounce_bit.sv - one key: 2-FF synchroniser, debounce counter, stable level and press pulse
module sc_debounce_bit
  import sc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam logic             RAW_IDLE = raw_idle_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s;

  assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Counter only advances while s disagrees; any agreement restarts the qualification window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (s != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s;
        pulse_d  = s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= RAW_IDLE;
      sync2_q  <= RAW_IDLE;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/sc_key_debouncer.sv
// rtl/sc_key_debouncer.sv - debounces key1/key2/key3 pins into levels and press pulses for the memory controller
module sc_key_debouncer
  import sc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_key1,
  input  logic [3:0] raw_key2,
  input  logic [3:0] raw_key3,
  output logic       key1,
  output logic [3:0] key2,
  output logic [3:0] key3,
  output logic [8:0] key_pressed
);

  logic [NUM_KEYS-1:0] raw_all;
  logic [NUM_KEYS-1:0] level_all;

  // Packing order matches key_pressed so one index serves levels and pulses.
  assign raw_all = {raw_key3, raw_key2, raw_key1};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_bit
    sc_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk_i  (clock),
      .rst_i  (reset),
      .raw_i  (raw_all[i]),
      .level_o(level_all[i]),
      .pulse_o(key_pressed[i])
    );
  end

  assign key1 = level_all[KEY1_IDX];
  assign key2 = level_all[KEY2_LSB +: 4];
  assign key3 = level_all[KEY3_LSB +: 4];

endmodule

// File: tb/tb_sc_key_debouncer.sv
// tb/tb_sc_key_debouncer.sv - directed self-checking bench for sc_key_debouncer with DEBOUNCE_CYCLES=4
module tb_sc_key_debouncer;

  logic       clock;
  logic       reset;
  logic       raw_key1;
  logic [3:0] raw_key2;
  logic [3:0] raw_key3;
  logic       key1;
  logic [3:0] key2;
  logic [3:0] key3;
  logic [8:0] key_pressed;

  int checks   = 0;
  int failures = 0;

  sc_key_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_key1   (raw_key1),
    .raw_key2   (raw_key2),
    .raw_key3   (raw_key3),
    .key1       (key1),
    .key2       (key2),
    .key3       (key3),
    .key_pressed(key_pressed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Levels use the same {key3,key2,key1} bit layout as key_pressed.
  task automatic chk(input string tag, input logic [8:0] exp_lvl, input logic [8:0] exp_pls);
    logic [17:0] obs;
    logic [17:0] expv;
    obs  = {key3, key2, key1, key_pressed};
    expv = {exp_lvl, exp_pls};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  initial begin
    logic [13:0] pat;
    logic [8:0]  lvl;
    logic [8:0]  pls;
    int          e;

    reset    = 1'b0;
    raw_key1 = 1'b1;
    raw_key2 = 4'hF;
    raw_key3 = 4'hF;

    // 1. asynchronous reset mid-cycle, then idle
    step(2);
    #3 reset = 1'b1;
    #1 chk("reset_async", 9'h000, 9'h000);
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle", 9'h000, 9'h000);
    end

    // 2. clean press and release of key1
    raw_key1 = 1'b0;
    step(5);
    chk("press_e5", 9'h000, 9'h000);
    step(1);
    chk("press_e6", 9'h001, 9'h001);
    step(1);
    chk("press_e7", 9'h001, 9'h000);
    raw_key1 = 1'b1;
    step(5);
    chk("release_e5", 9'h001, 9'h000);
    step(1);
    chk("release_e6", 9'h000, 9'h000);

    // 3. glitch of 3 cycles rejected, 4 cycles accepted
    raw_key2[2] = 1'b0;
    step(3);
    raw_key2[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch3", 9'h000, 9'h000);
    end
    raw_key2[2] = 1'b0;
    step(4);
    raw_key2[2] = 1'b1;
    step(1);
    chk("glitch4_e5", 9'h000, 9'h000);
    step(1);
    chk("glitch4_e6", 9'h008, 9'h008);
    step(1);
    chk("glitch4_e7", 9'h008, 9'h000);
    step(4);
    chk("glitch4_rel", 9'h000, 9'h000);

    // 4. bouncing press on key3[0]; final falling edge is applied after edge 5
    pat = 14'b00000000010010;
    for (int i = 0; i < 14; i++) begin
      raw_key3[0] = pat[i];
      step(1);
      e   = i + 1;
      lvl = (e >= 11) ? 9'h020 : 9'h000;
      pls = (e == 11) ? 9'h020 : 9'h000;
      chk("bounce", lvl, pls);
    end
    raw_key3 = 4'h0;
    step(5);
    chk("key3_all_e5", 9'h020, 9'h000);
    step(1);
    chk("key3_all_e6", 9'h1E0, 9'h1C0);
    step(1);
    chk("key3_all_e7", 9'h1E0, 9'h000);

    // 5. simultaneous release, then simultaneous press
    raw_key3 = 4'hF;
    step(5);
    chk("rel_all_e5", 9'h1E0, 9'h000);
    step(1);
    chk("rel_all_e6", 9'h000, 9'h000);
    raw_key1    = 1'b0;
    raw_key2[0] = 1'b0;
    step(5);
    chk("simul_e5", 9'h000, 9'h000);
    step(1);
    chk("simul_e6", 9'h003, 9'h003);
    step(1);
    chk("simul_e7", 9'h003, 9'h000);
    raw_key1    = 1'b1;
    raw_key2[0] = 1'b1;
    step(7);
    chk("simul_rel", 9'h000, 9'h000);

    // 6. reset pulse mid-count while key1 stays held
    raw_key1 = 1'b0;
    step(3);
    #3 reset = 1'b1;
    #1 chk("reset_midcount", 9'h000, 9'h000);
    @(posedge clock);
    #1 reset = 1'b0;
    step(5);
    chk("post_reset_e5", 9'h000, 9'h000);
    step(1);
    chk("post_reset_e6", 9'h001, 9'h001);
    step(1);
    chk("post_reset_e7", 9'h001, 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_key_debouncer.md
Name: sc_key_debouncer

Overview:
Input-side conditioning stage that feeds the key1/key2/key3 inputs of sc_mem_controller, the memory/I/O controller.
- Raw board push-buttons and switches are synchronised into the CPU clock domain and debounced per bit.
- Outputs are glitch-free logical levels plus single-cycle press pulses.
- The CPU reads the levels at I/O addresses 0x8000_0000, 0x8000_0004 and 0x8000_0008.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised bit must differ from its stable value before the stable value flips (1 ms at 50 MHz); must be >= 2.
CNT_W, $clog2(DEBOUNCE_CYCLES), counter width per bit.
ACTIVE_LOW, 1, 1 means raw pins read 0 when pressed and are inverted at the input; 0 means no inversion.

Ports:
clock  input  1  single system clock, the same clock that drives sc_mem_controller; all flops on rising edge.
reset  input  1  asynchronous, active-high reset.
raw_key1  input  1  raw pin for key1.
raw_key2  input  4  raw pins for key2.
raw_key3  input  4  raw pins for key3.
key1  output  1  debounced logical level; 1 means pressed/on.
key2  output  4  debounced logical levels.
key3  output  4  debounced logical levels.
key_pressed  output  9  one-cycle pulse on a 0->1 transition of the debounced level; bit 0 = key1, bits 4:1 = key2[3:0], bits 8:5 = key3[3:0].

Behaviour:
- Clocking and reset: one clock domain, `clock`. Reset is asynchronous and active-high, on port `reset`. Every flop is cleared immediately on reset assertion, independent of the clock.
- Reset values:
  - sync stage 1/2 hold the inactive raw level: 1 if ACTIVE_LOW, else 0.
  - stable = 0, counters = 0.
  - key1/key2/key3 = 0, key_pressed = 0.
- Input path, per bit: raw -> sync1 -> sync2 (2-FF synchroniser). s = ACTIVE_LOW ? ~sync2 : sync2.
- Per-bit update on each rising edge (s = current synchronised logical value):
  - s == stable: cnt <= 0; pulse <= 0.
  - s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s; cnt <= 0; pulse <= s (pulse only on a press, not a release).
  - s != stable otherwise: cnt <= cnt+1; pulse <= 0.
- Outputs: key* are the stable registers; key_pressed is the registered pulse. Both are registered outputs with no combinational path from raw pins.
- Latency:
  - A clean raw edge at edge 0 is seen as s after edge 2.
  - stable and pulse update at edge 2+DEBOUNCE_CYCLES.
- Filtering:
  - Any deviation of s lasting fewer than DEBOUNCE_CYCLES consecutive cycles returns cnt to 0 and leaves the output unchanged.
  - Bouncing restarts the count from 0 each time s returns to stable.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Bits are fully independent. Simultaneous changes on several bits may pulse in the same cycle.
- key_pressed is high for exactly one cycle per qualified press. A held key produces no further pulses; release produces no pulse.
- Reset mid-count: counters are discarded. After deassertion, a key already held is reported as a press after 2+DEBOUNCE_CYCLES cycles.
- A key held throughout reset produces exactly one pulse after reset.

Decomposition:
- Shared package sc_io_pkg:
  - I/O address constants: KEY1_ADDR 0x8000_0000, KEY2_ADDR 0x8000_0004, KEY3_ADDR 0x8000_0008, DISPLAY_ADDR 0x8000_000C.
  - key_pressed bit-index constants: KEY1_IDX 0, KEY2_LSB 1, KEY3_LSB 5.
- Sub-module sc_debounce_bit: one synchroniser, counter, stable register and pulse register, parameterised by DEBOUNCE_CYCLES and ACTIVE_LOW.
- Top-level instantiates sc_debounce_bit 9 times and concatenates the outputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
1. Reset and idle: assert reset mid-cycle with all raw=1 -> outputs 0 immediately (asynchronously); hold raw=1 for 20 cycles after release -> key*=0, key_pressed=0 throughout.
2. Clean press: raw_key1 1->0 at edge 0 and held -> key1=1 and key_pressed[0]=1 after edge 6; pulse low at edge 7; key1 stays 1.
3. Glitch rejection: raw_key2[2] low for 3 cycles then high -> key2 stays 4'b0000, no pulse. Low for 4 cycles -> key2=4'b0100 with one pulse on key_pressed[3].
4. Bounce: raw_key3[0] pattern 0,1,0,0,1,0,0,0,0,... -> counter restarts on each 1; key3[0] rises only 6 cycles after the final 1->0 edge; exactly one pulse on key_pressed[5].
5. Release and simultaneity: with key3=4'b1111 held, release all four raw bits at once -> key3=4'b0000 after 6 cycles, no pulse. Press key1 and key2[0] on the same edge -> key_pressed=9'b000000011 for one cycle.
6. Reset mid-count: raw_key1 low for 3 cycles, pulse reset, raw still low -> key1 rises, with one pulse, exactly 6 cycles after reset deassertion.
